// File: rtl/adc_xy_fb_pkg.sv
// adc_xy_fb_pkg
//   Shared definitions for the ADC X/Y to framebuffer address path:
//   VGA visible-area defaults, framebuffer size, the pixel type and the
//   1-bit-per-channel colour expansion helper.
package adc_xy_fb_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_V_VISIBLE = 480;
  localparam int FB_PIXEL_BITS = 12;
  localparam int FB_COLOR_BITS = FB_PIXEL_BITS / 3;
  localparam int FB_WORDS      = VGA_H_VISIBLE * VGA_V_VISIBLE;

  typedef logic [FB_PIXEL_BITS-1:0] pixel_t;

  // Each flag fills its whole channel: 1 -> all ones, 0 -> zero. Layout {R,G,B}.
  function automatic pixel_t color_expand(input logic r, input logic g, input logic b);
    return {{FB_COLOR_BITS{r}}, {FB_COLOR_BITS{g}}, {FB_COLOR_BITS{b}}};
  endfunction

endpackage

// File: rtl/adc_xy_fb_addr_sat_counter.sv
// sat_counter
//   Event counter that sticks at all ones instead of wrapping.
//   Ports:
//     clk   - clock
//     reset - synchronous, active-low reset (clears the count)
//     inc   - count one event this cycle
//     val   - current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] val
);

  logic [WIDTH-1:0] val_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      val_reg <= '0;
    end else if (inc && (val_reg != '1)) begin
      val_reg <= val_reg + WIDTH'(1);
    end
  end

  assign val = val_reg;

endmodule

// File: rtl/adc_xy_fb_addr.sv
// adc_xy_fb_addr
//   Turns captured ADC X/Y samples plus 1-bit colour flags into framebuffer
//   pixel-write requests. Three register stages: A (captured sample),
//   B (word address and pixel), O (output request). Off-screen samples are
//   dropped between A and B, consecutive identical writes between B and O.
//   Ports:
//     clk, reset                   - clock, synchronous active-low reset
//     s_valid/s_ready              - input sample handshake
//     s_x, s_y                     - sample coordinates
//     s_red, s_grn, s_blu          - colour flags
//     m_valid/m_ready              - write request handshake
//     m_addr, m_data               - framebuffer word address and {R,G,B} pixel
//     drop_clip_cnt, drop_dup_cnt  - saturating drop counters
module adc_xy_fb_addr
  import adc_xy_fb_pkg::*;
#(
  parameter int ADC_DATA_BITS  = 10,
  parameter int PIXEL_BITS     = FB_PIXEL_BITS,
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int H_VISIBLE      = VGA_H_VISIBLE,
  parameter int V_VISIBLE      = VGA_V_VISIBLE,
  parameter int CNT_BITS       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [ADC_DATA_BITS-1:0]  s_x,
  input  logic [ADC_DATA_BITS-1:0]  s_y,
  input  logic                      s_red,
  input  logic                      s_grn,
  input  logic                      s_blu,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [AXI_ADDR_WIDTH-1:0] m_addr,
  output logic [PIXEL_BITS-1:0]     m_data,
  output logic [CNT_BITS-1:0]       drop_clip_cnt,
  output logic [CNT_BITS-1:0]       drop_dup_cnt
);

  localparam int COLOR_BITS = PIXEL_BITS / 3;

  // Stage A
  logic                      a_vld_reg;
  logic                      a_clip_reg;
  logic [ADC_DATA_BITS-1:0]  a_x_reg;
  logic [ADC_DATA_BITS-1:0]  a_y_reg;
  logic [2:0]                a_rgb_reg;
  // Stage B
  logic                      b_vld_reg;
  logic [AXI_ADDR_WIDTH-1:0] b_addr_reg;
  logic [PIXEL_BITS-1:0]     b_pixel_reg;
  // Stage O
  logic                      o_vld_reg;
  logic [AXI_ADDR_WIDTH-1:0] o_addr_reg;
  logic [PIXEL_BITS-1:0]     o_data_reg;
  // Last emitted write, for duplicate suppression
  logic                      last_vld_reg;
  logic [AXI_ADDR_WIDTH-1:0] last_addr_reg;
  logic [PIXEL_BITS-1:0]     last_pixel_reg;

  logic                      s_clip;
  logic                      s_accept;
  logic                      o_pop, o_free;
  logic                      b_adv, b_dup, b_emit, b_free;
  logic                      a_adv, a_load_b;
  logic [AXI_ADDR_WIDTH-1:0] a_addr;
  logic [PIXEL_BITS-1:0]     a_pixel;

  assign s_clip = (int'(s_x) >= H_VISIBLE) || (int'(s_y) >= V_VISIBLE);

  // Each stage moves when the one after it is empty or being emptied now,
  // so the chain from m_ready back to s_ready is combinational.
  assign o_pop    = o_vld_reg && m_ready;
  assign o_free   = !o_vld_reg || o_pop;
  assign b_adv    = b_vld_reg && o_free;
  assign b_dup    = last_vld_reg && (b_addr_reg == last_addr_reg) && (b_pixel_reg == last_pixel_reg);
  assign b_emit   = b_adv && !b_dup;
  assign b_free   = !b_vld_reg || b_adv;
  assign a_adv    = a_vld_reg && b_free;
  assign a_load_b = a_adv && !a_clip_reg;

  // Held low during reset so nothing is taken while the pipeline is cleared.
  assign s_ready  = reset && (!a_vld_reg || a_adv);
  assign s_accept = s_valid && s_ready;

  // Row-major linear address, truncated to the bus width.
  assign a_addr = AXI_ADDR_WIDTH'(a_y_reg) * AXI_ADDR_WIDTH'(H_VISIBLE) + AXI_ADDR_WIDTH'(a_x_reg);

  genvar gi;
  generate
    if (PIXEL_BITS == FB_PIXEL_BITS) begin : g_pkg_expand
      assign a_pixel = color_expand(a_rgb_reg[2], a_rgb_reg[1], a_rgb_reg[0]);
    end else begin : g_rep_expand
      for (gi = 0; gi < COLOR_BITS; gi++) begin : g_chan
        assign a_pixel[2*COLOR_BITS+gi] = a_rgb_reg[2];
        assign a_pixel[COLOR_BITS+gi]   = a_rgb_reg[1];
        assign a_pixel[gi]              = a_rgb_reg[0];
      end
      if (PIXEL_BITS > 3*COLOR_BITS) begin : g_pad
        assign a_pixel[PIXEL_BITS-1:3*COLOR_BITS] = '0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_vld_reg      <= 1'b0;
      a_clip_reg     <= 1'b0;
      a_x_reg        <= '0;
      a_y_reg        <= '0;
      a_rgb_reg      <= '0;
      b_vld_reg      <= 1'b0;
      b_addr_reg     <= '0;
      b_pixel_reg    <= '0;
      o_vld_reg      <= 1'b0;
      o_addr_reg     <= '0;
      o_data_reg     <= '0;
      last_vld_reg   <= 1'b0;
      last_addr_reg  <= '0;
      last_pixel_reg <= '0;
    end else begin
      if (s_accept) begin
        a_vld_reg  <= 1'b1;
        a_clip_reg <= s_clip;
        a_x_reg    <= s_x;
        a_y_reg    <= s_y;
        a_rgb_reg  <= {s_red, s_grn, s_blu};
      end else if (a_adv) begin
        a_vld_reg  <= 1'b0;
      end

      // Clipped entries leave A without ever occupying B.
      if (a_load_b) begin
        b_vld_reg   <= 1'b1;
        b_addr_reg  <= a_addr;
        b_pixel_reg <= a_pixel;
      end else if (b_adv) begin
        b_vld_reg   <= 1'b0;
      end

      // O only reloads when free, which keeps m_addr/m_data stable under stall.
      if (b_emit) begin
        o_vld_reg      <= 1'b1;
        o_addr_reg     <= b_addr_reg;
        o_data_reg     <= b_pixel_reg;
        last_vld_reg   <= 1'b1;
        last_addr_reg  <= b_addr_reg;
        last_pixel_reg <= b_pixel_reg;
      end else if (o_pop) begin
        o_vld_reg      <= 1'b0;
      end
    end
  end

  assign m_valid = o_vld_reg;
  assign m_addr  = o_addr_reg;
  assign m_data  = o_data_reg;

  sat_counter #(.WIDTH(CNT_BITS)) u_clip_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (a_adv && a_clip_reg),
    .val   (drop_clip_cnt)
  );

  sat_counter #(.WIDTH(CNT_BITS)) u_dup_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (b_adv && b_dup),
    .val   (drop_dup_cnt)
  );

endmodule

// File: doc/adc_xy_fb_addr.md
# adc_xy_fb_addr

Converts captured ADC X/Y samples and their 1-bit colour flags into framebuffer pixel-write requests. It runs in the system clock domain, downstream of the ADC capture CDC FIFO and upstream of the fade/framebuffer SRAM writer. It clips samples to the visible area, linearises them to an SRAM word address, expands colour to pixel format and drops consecutive duplicate writes. It has a valid/ready handshake on both sides and runs at full throughput of one sample per cycle.

## Interface
- ADC_DATA_BITS, 10, width of each X/Y sample
- PIXEL_BITS, 12, pixel width; COLOR_BITS = PIXEL_BITS/3
- AXI_ADDR_WIDTH, 20, framebuffer address width
- H_VISIBLE, 640, visible columns
- V_VISIBLE, 480, visible rows
- CNT_BITS, 16, width of each drop counter
- clk  input  1  system clock; the block uses one clock
- reset  input  1  synchronous, active-low reset (block in reset while low at posedge clk)
- s_valid  input  1  input sample valid
- s_ready  output  1  block accepts the sample this cycle
- s_x, s_y  input  ADC_DATA_BITS  sample coordinates
- s_red, s_grn, s_blu  input  1  colour flags
- m_valid  output  1  write request valid
- m_ready  input  1  downstream accepts the request
- m_addr  output  AXI_ADDR_WIDTH  framebuffer word address
- m_data  output  PIXEL_BITS  pixel value {R,G,B}
- drop_clip_cnt  output  CNT_BITS  count of clipped samples, saturating
- drop_dup_cnt  output  CNT_BITS  count of duplicate samples dropped, saturating

## Operation
- Three register stages: A (captured sample), B (address and pixel), O (output).
- **Stage A.** Loads on s_valid && s_ready. It sets clip = (s_x >= H_VISIBLE) || (s_y >= V_VISIBLE).
- **A→B.** A clipped entry is discarded and does not occupy B. drop_clip_cnt increments once per discarded entry.
- **Stage B.** addr = s_y*H_VISIBLE + s_x, truncated to AXI_ADDR_WIDTH. Each colour channel is replicated to COLOR_BITS: a flag of 1 gives all ones, a flag of 0 gives zero.
- **B→O, duplicate check.** An entry is a duplicate when last_vld && addr == last_addr && pixel == last_pixel. A duplicate is discarded and drop_dup_cnt increments.
- **B→O, emit.** Otherwise the entry loads into O, and last_addr, last_pixel and last_vld update.
- **Stall propagation.** A stage advances when the next stage is empty or emptying this cycle. O empties on m_valid && m_ready.
- s_ready = !A_valid || A_advance. This is a combinational path from m_ready, which is allowed.
- **Output stability.** While m_valid && !m_ready, m_addr and m_data hold stable and m_valid stays high.
- **Counters.** They saturate at all ones. A clip event and a dup event in the same cycle both count.
- **Order.** Output order equals accepted input order, minus dropped entries.

## Timing
- Latency is 2 cycles: a sample accepted at edge N appears with m_valid after edge N+2, when there is no stall.
- Throughput is 1 per cycle with m_ready held at 1.
- Capacity is 3 entries (A, B, O). s_ready falls in the cycle A is full and cannot advance.
- Values while reset is low, and after the releasing edge:
  - s_ready = 0 while reset is low.
  - m_valid = 0, m_addr = 0, m_data = 0.
  - Both counters = 0, last_vld = 0, all stage valids = 0.
- Reset mid-operation discards in-flight entries without emitting them. The first post-reset sample is never flagged as a duplicate.
- The first cycle after release has s_ready = 1.

## Structure
- Shared package adc_xy_fb_pkg holds:
  - the pixel_t typedef;
  - the function color_expand(r, g, b) returning pixel_t;
  - the constant FB_WORDS = H_VISIBLE*V_VISIBLE.
- H_VISIBLE/V_VISIBLE defaults match the VGA mode definitions.
- One sub-module, sat_counter (parameter WIDTH; ports clk, reset, inc, val), is instantiated twice.

## Test plan
- **Single sample.** x=3, y=2, rgb=1/0/1 → m_valid 2 cycles later with m_addr=1283 and m_data=12'hF0F.
- **Clip boundary.**
  - x=640, y=0 → no output and drop_clip_cnt=1.
  - x=0, y=480 → no output and drop_clip_cnt=2.
  - x=639, y=479 → m_addr=307199.
- **Duplicates.**
  - (10,10, rgb 111) twice → one output and drop_dup_cnt=1.
  - Then (10,10, rgb 100) → output with m_data=12'hF00.
  - Then (10,10, rgb 111) → output, because only consecutive duplicates are dropped.
- **Backpressure.**
  - Hold m_ready=0 and offer 5 distinct samples → 3 are accepted, then s_ready=0, and m_addr/m_data stay stable.
  - Release m_ready → all 5 emerge in order, with no loss.
- **Reset mid-stream.**
  - Drive reset=0 with 3 entries in flight → m_valid=0 and counters=0 after the edge.
  - Resend the last pre-reset sample → it is emitted, not deduped.
- **Throughput.** 100 distinct in-range samples back-to-back with m_ready=1 → 100 outputs within 102 cycles, and s_ready stays 1 throughout.
